// File: rtl/serial_add_if.sv
// Handshake and operand/result bundle between the datapath and the bit-serial adder sequencer.
interface serial_add_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell, LSB first, WIDTH+1 cycles per result.
//
// state | meaning
// IDLE  | waiting for start, last result held on outputs
// RUN   | one operand bit pair per clock through the adder cell
// DONE  | one-cycle done pulse; start here chains the next operation
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    serial_add_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic             ovf_q;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;
    logic             last_bit;
    logic             accept;
    logic             busy_o;
    logic             done_o;

    assign fa_s     = a_sr[0] ^ b_sr[0] ^ carry;
    assign fa_c     = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign accept   = (state != RUN) && bus.start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.start ? RUN : IDLE;
            RUN:     state_nxt = last_bit ? DONE : RUN;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state)
            RUN:     busy_o = 1'b1;
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    // Subtraction is a + ~b + 1: the +1 arrives as the initial carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            s_sr   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            a_sr  <= bus.a;
            b_sr  <= bus.sub ? ~bus.b : bus.b;
            s_sr  <= '0;
            carry <= bus.sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            s_sr  <= {fa_s, s_sr[WIDTH-1:1]};
            carry <= fa_c;
            if (last_bit) begin
                cnt    <= '0;
                sum_q  <= {fa_s, s_sr[WIDTH-1:1]};
                cout_q <= fa_c;
                // carry still holds the carry into the MSB on this edge
                ovf_q  <= carry ^ fa_c;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.busy = busy_o;
    assign bus.done = done_o;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Sequencer that reuses a single fulladder cell to add or subtract two WIDTH-bit operands bit-serially, one bit per clock, LSB first. It owns the operand shift registers, the carry flip-flop, the bit counter and a start/busy/done handshake. It presents parallel results to the surrounding datapath. It trades WIDTH+1 cycles of latency for one adder cell in place of a ripple chain.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..32)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a new operation; sampled only when busy=0
sub  input  1  0 = a+b, 1 = a-b; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; result outputs valid from this cycle
sum  output  WIDTH  registered result
cout  output  1  raw carry out of MSB (for sub: 1 = no borrow)
ovf  output  1  signed two's-complement overflow

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (ports clk, rst).
- While rst=1, and immediately when it asserts: state=IDLE; busy, done, sum, cout and ovf all 0; shift registers, carry and counter cleared.
- Reset asserted mid-operation aborts the operation. No done pulse is produced and outputs read 0.
- FSM states: IDLE, RUN, DONE.
- IDLE to RUN on an edge with start=1:
  - load A_sr<=a and B_sr<=(sub ? ~b : b);
  - carry<=sub;
  - cnt<=0;
  - latch sub internally;
  - busy=1 from the next cycle.
- RUN: each edge, the fulladder cell takes inputs A_sr[0], B_sr[0] and carry. On that edge:
  - S_sr shifts right with the cell's sum entering at the MSB;
  - A_sr and B_sr shift right;
  - carry<=cell cout;
  - cnt<=cnt+1.
- Before updating carry on the edge with cnt=WIDTH-1, capture the carry into the MSB as cmsb.
- RUN to DONE on the edge where cnt=WIDTH-1, i.e. the WIDTH-th RUN edge. On that same edge:
  - sum<=final S_sr value, including the bit from that edge;
  - cout<=final cell cout;
  - ovf<=cmsb XOR final cout.
- DONE: done=1 and busy=0 for exactly one cycle.
  - start=1 here is accepted exactly as in IDLE and goes to RUN, giving a back-to-back throughput of WIDTH+1 cycles.
  - Otherwise go to IDLE.
- Latency: with start sampled at edge E, done is high in the cycle after edge E+WIDTH. sum, cout and ovf change only at that edge.
- busy=1 exactly in RUN. start, a, b and sub are ignored while busy=1.
- Outputs hold their last result through IDLE until the next completion or reset. They do not show intermediate shifting.
- Arithmetic is modulo 2^WIDTH. Subtraction is a + ~b + 1 with no separate borrow logic.
- Counter width is clog2(WIDTH), and cnt never exceeds WIDTH-1.
- No combinational path from any input to any output.

Test Plan:
- Add, WIDTH=8: a=0x3C, b=0x05, sub=0 -> done pulse 8 cycles after the start edge; sum=0x41, cout=0, ovf=0. busy high for exactly 8 cycles.
- Unsigned wrap: a=0xFF, b=0x01, sub=0 -> sum=0x00, cout=1, ovf=0.
- Signed overflow:
  - a=0x7F, b=0x01, sub=0 -> sum=0x80, cout=0, ovf=1;
  - a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
- Subtract with borrow: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0, ovf=0. Then a=0x07, b=0x05, sub=1 -> sum=0x02, cout=1.
- Start while busy: issue a second start with a=0xAA, b=0x11 three cycles after the first start -> ignored. A single done pulse appears with the first result.
- Back-to-back and reset:
  - start held high across the DONE cycle -> second operation begins and its done appears 9 cycles after the first done.
  - rst pulsed at RUN cycle 4 -> outputs 0 immediately, no done pulse.
  - A subsequent 0x01+0x01 gives sum=0x02.
